dec_scan: RTL and testbench
===========================

# dec_scan

Parametrised, registered N-to-2^N one-hot decoder with a built-in auto-scan sequencer. In direct mode it decodes a select input exactly as the team's combinational decoders do, but with a registered output. In scan mode it steps its own index through all 2^N outputs with a programmable dwell, for multiplexed display-digit or row strobing. It sits between control logic and strobe/enable fan-out in the lab designs.

## Interface
Parameters:
- N, default 2: select width; output width is 2^N (N ≥ 1).
- DWELL, default 4: clock cycles each output stays active in scan mode (DWELL ≥ 1).

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  global enable; 0 forces outputs to zero and freezes state.
- mode  input  1  0 = direct decode, 1 = auto-scan.
- a  input  N  select value: the decode target in direct mode, the start index on load or scan entry.
- load  input  1  scan mode only: jump index to a and restart the dwell.
- d  output  2^N  registered one-hot output; d[idx] = 1 when active.
- idx  output  N  current registered index.
- wrap  output  1  one-cycle pulse when a scan step wraps idx from 2^N−1 to 0.

## Operation
- Internal state: state register {OFF, DIRECT, SCAN}, idx (N bits), dwell counter (width ceil(log2(DWELL)), min 1), and a prev_mode register for entry detection.
- Priority at each clk edge: rst > en=0 > mode change > load > dwell step.
- rst=1: state=OFF, idx=0, dwell=0, d=0, wrap=0, prev_mode=0.
- en=0: state=OFF, d=0, wrap=0. idx, dwell and prev_mode hold their values.
- en=1, mode=0 (DIRECT): idx←a, d←one-hot(a), dwell←0, wrap=0. load is ignored.
- en=1, mode=1, entering SCAN (previous state OFF or DIRECT, or prev_mode=0): idx←a, d←one-hot(a), dwell←0, wrap=0.
- In SCAN with load=1: idx←a, dwell←0, wrap=0. load wins over a coincident step.
- In SCAN otherwise:
  - If dwell = DWELL−1: dwell←0 and idx←(idx+1) mod 2^N. wrap←1 only if the old idx was 2^N−1.
  - Else: dwell←dwell+1, wrap←0.
- d always equals one-hot(idx) whenever the state is DIRECT or SCAN. d is 0 in OFF. d is never multi-hot.
- idx arithmetic is unsigned modulo 2^N with no saturation.
- Re-enabling (en 0→1) while mode=1 counts as SCAN entry: idx reloads from a and the dwell restarts.

## Timing
- All outputs are registered; no combinational path from any input to any output.
- Direct-mode latency: a sampled at edge k appears on d/idx after edge k (1 cycle).
- Scan entry, load, or re-enable at edge k: the new idx is visible after edge k and holds for exactly DWELL cycles, then steps.
- Steady scan: each idx is held DWELL cycles. A full period is DWELL·2^N cycles, with exactly one wrap pulse per period, coincident with idx=0.
- DWELL=1: idx advances every cycle and wrap fires every 2^N cycles.
- A mode change on the same edge as load: the entry rule applies (idx←a). The result is identical either way.
- rst asserted mid-scan: outputs are zero on the next edge. After release with en=1, mode=1, scan restarts from a (treated as entry).
- Reset values: d=0, idx=0, wrap=0.

## Test plan
- Reset/enable, N=2, DWELL=4: rst=1 for 2 cycles, then en=0, a=2'b10 → d=4'b0000, idx=0, wrap=0. Then en=1, mode=0 → d=4'b0100 one cycle later.
- Direct sweep, N=2: en=1, mode=0, a=00,01,10,11 on consecutive cycles → d=0001,0010,0100,1000, each one cycle after its a.
- Scan, N=2, DWELL=4: mode 0→1 with a=2'b01 → idx 1,2,3 for 4 cycles each, then idx=0 with wrap=1 for one cycle, period 16 cycles.
- Load and freeze: during scan at idx=2, dwell=1, assert load with a=2'b11 → idx=3 for a full 4 cycles, then 0 with wrap=1. Drop en mid-dwell → d=0. Raise en → restart from a.
- Edge parameters: N=3, DWELL=1, scan from a=0 → d walks 8'h01…8'h80 one step per cycle, wrap every 8 cycles. Verify d is one-hot or zero every cycle.
- Reset mid-scan: assert rst at idx=3 → d=0, idx=0, wrap=0 after the edge. Release with mode=1, a=2'b10 → idx=2 on the next edge.

Source files
------------

// File: rtl/dec_scan.sv
// Registered N-to-2^N one-hot decoder with an auto-scan sequencer (direct decode or timed index sweep).
// Latency: 1 cycle from any sampled input to d/idx/wrap; all outputs come straight from flops.
// Backpressure: none; the block always accepts its inputs, and en=0 freezes state and blanks the outputs.
//
// Ports:
//   i_clk    rising-edge clock
//   i_rst    synchronous active-high reset
//   i_en     global enable; low forces outputs to zero and holds idx/dwell/prev_mode
//   i_mode   0 = direct decode of i_a, 1 = auto-scan
//   i_a      decode target (direct) or start index (scan entry / load)
//   i_load   scan mode only: jump to i_a and restart the dwell
//   o_d      registered one-hot output, zero when off
//   o_idx    current registered index
//   o_wrap   one-cycle pulse when a scan step wraps idx from 2^N-1 to 0
module dec_scan #(
    parameter int N     = 2,
    parameter int DWELL = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_mode,
    input  logic [N-1:0]     i_a,
    input  logic             i_load,
    output logic [2**N-1:0]  o_d,
    output logic [N-1:0]     o_idx,
    output logic             o_wrap
);

    localparam int W  = 2**N;
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
    localparam logic [N-1:0]  IDX_MAX    = {N{1'b1}};
    localparam logic [W-1:0]  ONE_HOT0   = {{(W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    state_t          r_state;
    logic [N-1:0]    r_idx;
    logic [DW-1:0]   r_dwell;
    logic            r_prev_mode;
    logic            r_wrap;
    logic [W-1:0]    r_d;

    state_t          w_state_nxt;
    logic [N-1:0]    w_idx_nxt;
    logic [DW-1:0]   w_dwell_nxt;
    logic            w_prev_mode_nxt;
    logic            w_wrap_nxt;
    logic [W-1:0]    w_d_nxt;
    logic            w_entry;

    // Scan is (re)entered whenever we were not already scanning: coming out of
    // OFF (re-enable, post-reset) or DIRECT, or the last enabled cycle was direct.
    assign w_entry = (r_state != ST_SCAN) || !r_prev_mode;

    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_dwell_nxt     = r_dwell;
        w_prev_mode_nxt = r_prev_mode;
        w_wrap_nxt      = 1'b0;

        if (!i_en) begin
            w_state_nxt = ST_OFF;
        end else if (!i_mode) begin
            w_state_nxt     = ST_DIRECT;
            w_idx_nxt       = i_a;
            w_dwell_nxt     = '0;
            w_prev_mode_nxt = 1'b0;
        end else if (w_entry || i_load) begin
            // Entry and load have the same effect, so a coincident pair is harmless.
            w_state_nxt     = ST_SCAN;
            w_idx_nxt       = i_a;
            w_dwell_nxt     = '0;
            w_prev_mode_nxt = 1'b1;
        end else begin
            w_state_nxt     = ST_SCAN;
            w_prev_mode_nxt = 1'b1;
            if (r_dwell == DWELL_LAST) begin
                w_dwell_nxt = '0;
                w_idx_nxt   = r_idx + N'(1);
                w_wrap_nxt  = (r_idx == IDX_MAX);
            end else begin
                w_dwell_nxt = r_dwell + DW'(1);
            end
        end

        // d is derived from the next index so it lands in the same edge as idx.
        w_d_nxt = (w_state_nxt == ST_OFF) ? '0 : (ONE_HOT0 << w_idx_nxt);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_OFF;
            r_idx       <= '0;
            r_dwell     <= '0;
            r_prev_mode <= 1'b0;
            r_wrap      <= 1'b0;
            r_d         <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_dwell     <= w_dwell_nxt;
            r_prev_mode <= w_prev_mode_nxt;
            r_wrap      <= w_wrap_nxt;
            r_d         <= w_d_nxt;
        end
    end

    assign o_d    = r_d;
    assign o_idx  = r_idx;
    assign o_wrap = r_wrap;

endmodule

// File: tb/tb_dec_scan.sv
// Bench for dec_scan: a 2/4 instance (N=2, DWELL=4) and a 3/1 instance (N=3, DWELL=1).
// Latency: stimulus applied on the falling edge, expectations checked 1 time unit after the next rising edge.
// Backpressure: none; a monitor pops one expectation per cycle per instance whenever one is queued.
module tb_dec_scan;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // instance A: N=2, DWELL=4
    logic        a_rst, a_en, a_mode, a_load;
    logic [1:0]  a_a;
    logic [3:0]  a_d;
    logic [1:0]  a_idx;
    logic        a_wrap;

    // instance B: N=3, DWELL=1
    logic        b_rst, b_en, b_mode, b_load;
    logic [2:0]  b_a;
    logic [7:0]  b_d;
    logic [2:0]  b_idx;
    logic        b_wrap;

    dec_scan #(.N(2), .DWELL(4)) u_dut_a (
        .i_clk (clk), .i_rst (a_rst), .i_en (a_en), .i_mode (a_mode),
        .i_a (a_a), .i_load (a_load),
        .o_d (a_d), .o_idx (a_idx), .o_wrap (a_wrap)
    );

    dec_scan #(.N(3), .DWELL(1)) u_dut_b (
        .i_clk (clk), .i_rst (b_rst), .i_en (b_en), .i_mode (b_mode),
        .i_a (b_a), .i_load (b_load),
        .o_d (b_d), .o_idx (b_idx), .o_wrap (b_wrap)
    );

    int checks = 0;
    int errors = 0;

    // expected {d, idx, wrap}
    logic [6:0]  qa[$];
    logic [11:0] qb[$];
    string       na[$];
    string       nb[$];

    task automatic expa(input string nm, input logic [3:0] d, input logic [1:0] idx, input logic wrap);
        qa.push_back({d, idx, wrap});
        na.push_back(nm);
    endtask

    task automatic expb(input string nm, input logic [7:0] d, input logic [2:0] idx, input logic wrap);
        qb.push_back({d, idx, wrap});
        nb.push_back(nm);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Monitor: one comparison per queued expectation, plus a one-hot-or-zero check every cycle.
    always @(posedge clk) begin
        logic [6:0]  ea;
        logic [11:0] eb;
        string       nm;
        #1;
        checks++;
        if ($countones(a_d) > 1) begin
            errors++;
            $display("FAIL onehot_a: d=%b is multi-hot, required one-hot or zero", a_d);
        end
        checks++;
        if ($countones(b_d) > 1) begin
            errors++;
            $display("FAIL onehot_b: d=%b is multi-hot, required one-hot or zero", b_d);
        end
        if (qa.size() > 0) begin
            ea = qa.pop_front();
            nm = na.pop_front();
            checks++;
            if ({a_d, a_idx, a_wrap} !== ea) begin
                errors++;
                $display("FAIL %s @%0t: got d=%b idx=%0d wrap=%b, required d=%b idx=%0d wrap=%b",
                         nm, $time, a_d, a_idx, a_wrap, ea[6:3], ea[2:1], ea[0]);
            end
        end
        if (qb.size() > 0) begin
            eb = qb.pop_front();
            nm = nb.pop_front();
            checks++;
            if ({b_d, b_idx, b_wrap} !== eb) begin
                errors++;
                $display("FAIL %s @%0t: got d=%h idx=%0d wrap=%b, required d=%h idx=%0d wrap=%b",
                         nm, $time, b_d, b_idx, b_wrap, eb[11:4], eb[3:1], eb[0]);
            end
        end
    end

    initial begin
        logic [1:0] ei;
        logic [2:0] bi;
        logic [3:0] ed;
        logic [7:0] bd;

        a_rst = 1'b1; a_en = 1'b0; a_mode = 1'b0; a_load = 1'b0; a_a = 2'd0;
        b_rst = 1'b1; b_en = 1'b0; b_mode = 1'b0; b_load = 1'b0; b_a = 3'd0;

        // reset for two cycles
        expa("reset0", 4'b0000, 2'd0, 1'b0); tick();
        expa("reset1", 4'b0000, 2'd0, 1'b0); tick();

        // disabled: outputs stay zero regardless of a
        a_rst = 1'b0; a_a = 2'b10;
        expa("disabled", 4'b0000, 2'd0, 1'b0); tick();

        // enable in direct mode
        a_en = 1'b1;
        expa("direct_en", 4'b0100, 2'd2, 1'b0); tick();

        // direct sweep
        a_a = 2'd0; expa("direct_00", 4'b0001, 2'd0, 1'b0); tick();
        a_a = 2'd1; expa("direct_01", 4'b0010, 2'd1, 1'b0); tick();
        a_a = 2'd2; expa("direct_10", 4'b0100, 2'd2, 1'b0); tick();
        a_a = 2'd3; expa("direct_11", 4'b1000, 2'd3, 1'b0); tick();

        // scan entry from a=1: idx 1,2,3 four cycles each, then 0 with wrap, ...
        a_mode = 1'b1; a_a = 2'd1;
        for (int c = 0; c < 22; c++) begin
            ei = 2'((1 + c / 4) % 4);
            ed = 4'b0001 << ei;
            expa("scan_run", ed, ei, (c == 12) ? 1'b1 : 1'b0);
            tick();
        end

        // now idx=2, dwell=1: load a=3 holds idx=3 for four cycles then wraps
        a_load = 1'b1; a_a = 2'd3;
        expa("load_jump", 4'b1000, 2'd3, 1'b0); tick();
        a_load = 1'b0; a_a = 2'd0;
        for (int c = 0; c < 3; c++) begin
            expa("load_hold", 4'b1000, 2'd3, 1'b0); tick();
        end
        expa("load_wrap", 4'b0001, 2'd0, 1'b1); tick();
        expa("after_wrap", 4'b0001, 2'd0, 1'b0); tick();

        // drop en mid-dwell: blanked, idx held
        a_en = 1'b0; a_a = 2'd2;
        expa("freeze0", 4'b0000, 2'd0, 1'b0); tick();
        expa("freeze1", 4'b0000, 2'd0, 1'b0); tick();

        // re-enable in scan mode restarts from a with a full dwell
        a_en = 1'b1;
        for (int c = 0; c < 4; c++) begin
            expa("reenable", 4'b0100, 2'd2, 1'b0); tick();
        end
        expa("reenable_step", 4'b1000, 2'd3, 1'b0); tick();

        // reset mid-scan at idx=3
        a_rst = 1'b1;
        expa("rst_midscan", 4'b0000, 2'd0, 1'b0); tick();
        a_rst = 1'b0; a_a = 2'd2;
        expa("rst_release", 4'b0100, 2'd2, 1'b0); tick();
        expa("rst_release_hold", 4'b0100, 2'd2, 1'b0); tick();

        // mode change coincident with load: entry takes a
        a_mode = 1'b0; a_a = 2'd1;
        expa("direct_again", 4'b0010, 2'd1, 1'b0); tick();
        a_mode = 1'b1; a_load = 1'b1; a_a = 2'd3;
        expa("entry_with_load", 4'b1000, 2'd3, 1'b0); tick();
        a_load = 1'b0;
        for (int c = 0; c < 3; c++) begin
            expa("entry_hold", 4'b1000, 2'd3, 1'b0); tick();
        end
        expa("entry_wrap", 4'b0001, 2'd0, 1'b1); tick();

        // instance B: N=3, DWELL=1, scan from 0, steps every cycle, wrap every 8
        expb("b_reset", 8'h00, 3'd0, 1'b0); tick();
        b_rst = 1'b0; b_en = 1'b1; b_mode = 1'b1; b_a = 3'd0;
        for (int c = 0; c < 20; c++) begin
            bi = 3'(c % 8);
            bd = 8'h01 << bi;
            expb("b_walk", bd, bi, (c == 8 || c == 16) ? 1'b1 : 1'b0);
            tick();
        end

        tick();
        tick();
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d/%0d expectations unconsumed, required 0/0", qa.size(), qb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
